// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: holds the fetch PC, fetches over a req/gnt/rvalid port, flags AdEL.
// Latency: PC load -> F_valid two cycles later with gnt/rvalid back-to-back; one cycle for AdEL.
// Backpressure: pc_en=0 holds a fetched instruction; fetch_busy stalls the pipe until one is held.
module f_fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        pc_en,
  input  logic        Req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_valid,
  output logic [4:0]  F_ExcCode,
  output logic        fetch_busy
);

  localparam logic [1:0] S_REQ  = 2'd0;  // request pending
  localparam logic [1:0] S_WAIT = 2'd1;  // granted, awaiting response
  localparam logic [1:0] S_HAVE = 2'd2;  // instruction (or AdEL) held
  localparam logic [1:0] S_DROP = 2'd3;  // awaiting a stale response to discard

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  exc;

  // Misaligned or outside the instruction memory window.
  function automatic logic adel(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
  endfunction

  // Fetch FSM, PC register and F/D output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RESET;
      state <= S_REQ;
      instr <= 32'h0;
      exc   <= EXC_NONE;
    end else if (Req) begin
      pc <= EXC_ENTRY;
      // A granted request or an outstanding one without its response yet
      // leaves a response in flight that must be swallowed first.
      if ((state == S_REQ && imem_gnt) ||
          (state == S_WAIT && !imem_rvalid) ||
          (state == S_DROP && !imem_rvalid)) begin
        state <= S_DROP;
      end else if (adel(EXC_ENTRY)) begin
        state <= S_HAVE;
        instr <= 32'h0;
        exc   <= EXC_ADEL;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            exc   <= EXC_NONE;
            state <= S_HAVE;
          end
        end
        S_HAVE: begin
          if (pc_en) begin
            pc <= NPC;
            if (adel(NPC)) begin
              instr <= 32'h0;
              exc   <= EXC_ADEL;
            end else begin
              state <= S_REQ;
            end
          end
        end
        default: begin  // S_DROP
          if (imem_rvalid) begin
            if (adel(pc)) begin
              state <= S_HAVE;
              instr <= 32'h0;
              exc   <= EXC_ADEL;
            end else begin
              state <= S_REQ;
            end
          end
        end
      endcase
    end
  end

  // Outputs decode directly from state; request is suppressed during reset.
  always_comb begin
    imem_req   = (state == S_REQ) && !reset;
    imem_addr  = pc;
    F_PC       = pc;
    F_Instr    = instr;
    F_ExcCode  = exc;
    F_valid    = (state == S_HAVE);
    fetch_busy = (state != S_HAVE);
  end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: linear stimulus, outputs checked 1 time unit after each rising edge.
// Memory side is driven by hand per step; each check is an immediate assertion.
// Fixed-length sequence, always reaches the summary line.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        pc_en;
  logic        Req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_valid;
  logic [4:0]  F_ExcCode;
  logic        fetch_busy;

  int n_cmp = 0;
  int n_err = 0;

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .NPC(NPC), .pc_en(pc_en), .Req(Req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .F_PC(F_PC), .F_Instr(F_Instr), .F_valid(F_valid),
    .F_ExcCode(F_ExcCode), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant now, respond next cycle with data; ends with the DUT in HAVE.
  task automatic fetch(input logic [31:0] data);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic check_have(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [4:0] ec);
    chk({tag, "_valid"}, {31'h0, F_valid}, 32'h1);
    chk({tag, "_pc"},    F_PC, pc);
    chk({tag, "_instr"}, F_Instr, ins);
    chk({tag, "_exc"},   {27'h0, F_ExcCode}, {27'h0, ec});
  endtask

  initial begin
    logic [31:0] bad_pcs [3];
    bad_pcs[0] = 32'h0000_3002;
    bad_pcs[1] = 32'h0000_7000;
    bad_pcs[2] = 32'h0000_2FFC;

    reset = 1'b1; NPC = 32'h0; pc_en = 1'b0; Req = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("req_forced_low_in_reset", {31'h0, imem_req}, 32'h0);
    tick();
    chk("rst_pc",    F_PC, 32'h0000_3000);
    chk("rst_valid", {31'h0, F_valid}, 32'h0);
    chk("rst_busy",  {31'h0, fetch_busy}, 32'h1);
    chk("rst_instr", F_Instr, 32'h0);
    chk("rst_exc",   {27'h0, F_ExcCode}, 32'h0);
    reset = 1'b0;
    #1;
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Minimum-latency fetch: gnt in cycle 0, rvalid in cycle 1, valid in cycle 2.
    imem_gnt = 1'b1;
    tick();
    chk("wait_not_valid", {31'h0, F_valid}, 32'h0);
    chk("wait_no_req",    {31'h0, imem_req}, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3C01_0001;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    check_have("first", 32'h0000_3000, 32'h3C01_0001, 5'd0);
    chk("first_busy", {31'h0, fetch_busy}, 32'h0);

    // Stall: outputs stable for 5 cycles even with a different NPC present.
    NPC = 32'h0000_3004;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_have("stall", 32'h0000_3000, 32'h3C01_0001, 5'd0);
    end
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    chk("adv_addr", imem_addr, 32'h0000_3004);
    chk("adv_busy", {31'h0, fetch_busy}, 32'h1);
    chk("adv_req",  {31'h0, imem_req}, 32'h1);
    fetch(32'h8C22_0004);
    check_have("second", 32'h0000_3004, 32'h8C22_0004, 5'd0);

    // AdEL: misaligned, above IM_HI, below IM_LO.
    for (int i = 0; i < 3; i++) begin
      NPC = bad_pcs[i]; pc_en = 1'b1;
      tick();
      pc_en = 1'b0;
      chk("adel_no_req", {31'h0, imem_req}, 32'h0);
      check_have("adel", bad_pcs[i], 32'h0, 5'd4);
    end

    // Highest legal address is fetched normally.
    NPC = 32'h0000_6FFC; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    chk("hi_req",  {31'h0, imem_req}, 32'h1);
    chk("hi_addr", imem_addr, 32'h0000_6FFC);
    fetch(32'h1234_5678);
    check_have("hi", 32'h0000_6FFC, 32'h1234_5678, 5'd0);

    // Req while WAIT for 0x3008: stale DEADBEEF dropped, 0x4180 fetched.
    NPC = 32'h0000_3008; pc_en = 1'b1;
    tick();
    pc_en = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; Req = 1'b1;
    tick();
    Req = 1'b0;
    chk("drop_pc",   F_PC, 32'h0000_4180);
    chk("drop_noreq", {31'h0, imem_req}, 32'h0);
    chk("drop_busy", {31'h0, fetch_busy}, 32'h1);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    chk("post_drop_req",   {31'h0, imem_req}, 32'h1);
    chk("post_drop_addr",  imem_addr, 32'h0000_4180);
    chk("post_drop_valid", {31'h0, F_valid}, 32'h0);
    fetch(32'h2408_0180);
    check_have("exc", 32'h0000_4180, 32'h2408_0180, 5'd0);

    // Req in REQ while ungranted: address switches, request stays up, no drop.
    NPC = 32'h0000_300C; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    chk("ungr_addr0", imem_addr, 32'h0000_300C);
    tick();
    Req = 1'b1;
    tick();
    Req = 1'b0;
    chk("ungr_addr1", imem_addr, 32'h0000_4180);
    chk("ungr_req1",  {31'h0, imem_req}, 32'h1);
    tick();
    chk("ungr_req2",  {31'h0, imem_req}, 32'h1);
    fetch(32'hAAAA_0001);
    check_have("ungr", 32'h0000_4180, 32'hAAAA_0001, 5'd0);

    // Req coincident with gnt: DROP entered, first response discarded.
    NPC = 32'h0000_3010; pc_en = 1'b1;
    tick();
    pc_en = 1'b0; imem_gnt = 1'b1; Req = 1'b1;
    tick();
    imem_gnt = 1'b0; Req = 1'b0;
    chk("cgnt_noreq", {31'h0, imem_req}, 32'h0);
    chk("cgnt_pc",    F_PC, 32'h0000_4180);
    tick();
    chk("cgnt_still_drop", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    chk("cgnt_valid", {31'h0, F_valid}, 32'h0);
    chk("cgnt_req",   {31'h0, imem_req}, 32'h1);
    fetch(32'hBBBB_0002);
    check_have("cgnt", 32'h0000_4180, 32'hBBBB_0002, 5'd0);

    // Reset while WAIT: restart cleanly at PC_RESET.
    NPC = 32'h0000_3014; pc_en = 1'b1;
    tick();
    pc_en = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_pc",    F_PC, 32'h0000_3000);
    chk("rst2_valid", {31'h0, F_valid}, 32'h0);
    chk("rst2_req",   {31'h0, imem_req}, 32'h1);
    chk("rst2_exc",   {27'h0, F_ExcCode}, 32'h0);
    fetch(32'h3C01_0001);
    check_have("rst2", 32'h0000_3000, 32'h3C01_0001, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
